// File: rtl/seq_pkg.sv
// Shared opcode encodings, FSM state type and debug view for the instruction sequencer.
package seq_pkg;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_t;

    typedef struct packed {
        seq_state_t state;
        logic       z;
        logic       c;
        logic       v;
        logic       at_limit;
    } seq_dbg_t;

    // Control opcodes are consumed by the sequencer and never reach the processor.
    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_HALT) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: PROG_DEPTH x 8 array with synchronous write and combinational read.
module seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // No reset: program contents survive rst_n.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches program words, runs HALT/JMP/JZ/JC itself, issues data ops.
// Optional macro SEQ_WATCHDOG_EN bounds each run to WDOG_LIMIT issued instructions.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter  int PROG_DEPTH = 16,
    parameter  int WDOG_LIMIT = 255,
    localparam int PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [7:0]      prog_wdata,
    output logic [7:0]      instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            res_valid,
    input  logic            zero_flag,
    input  logic            carry_flag,
    input  logic            overflow_flag,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic [7:0]      issue_count,
    output logic            wdog_err,
    output seq_dbg_t        o_dbg
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

    seq_state_t      r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [7:0]      r_instr;
    logic            r_instr_valid;
    logic            r_halted;
    logic            r_wdog_err;
    logic [7:0]      r_issue_count;
    logic            r_z;
    logic            r_c;
    logic            r_v;

    logic            w_busy;
    logic            w_mem_we;
    logic [7:0]      w_mem_rdata;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_target;
    logic            w_at_limit;
    logic            w_wdog_hit;

    assign w_busy     = (r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_WAIT);
    assign w_mem_we   = prog_we && !w_busy;
    assign w_pc_next  = (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;
    assign w_target   = PC_W'(r_ir[3:0]);
    assign w_at_limit = ({24'd0, r_issue_count} >= WDOG_LIMIT);

`ifdef SEQ_WATCHDOG_EN
    assign w_wdog_hit = w_at_limit;
`else
    assign w_wdog_hit = 1'b0;
`endif

    seq_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (PC_W)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_wdata),
        .i_raddr (r_pc),
        .o_rdata (w_mem_rdata)
    );

    // Handshake: instr_valid rises on entry to EXEC for a data opcode and holds instr
    // constant until a cycle with instr_valid && instr_ready; that edge is the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_ir          <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_wdog_err    <= 1'b0;
            r_issue_count <= '0;
            r_z           <= 1'b0;
            r_c           <= 1'b0;
            r_v           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state       <= ST_FETCH;
                        r_pc          <= '0;
                        r_z           <= 1'b0;
                        r_c           <= 1'b0;
                        r_v           <= 1'b0;
                        r_issue_count <= '0;
                        r_halted      <= 1'b0;
                        r_wdog_err    <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= w_mem_rdata;
                    r_state <= ST_EXEC;
                    if (!is_ctrl(w_mem_rdata[7:4]) && !w_wdog_hit) begin
                        r_instr       <= w_mem_rdata;
                        r_instr_valid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (is_ctrl(r_ir[7:4])) begin
                        case (r_ir[7:4])
                            OP_HALT: begin
                                r_state  <= ST_HALT;
                                r_halted <= 1'b1;
                            end
                            OP_JMP: begin
                                r_pc    <= w_target;
                                r_state <= ST_FETCH;
                            end
                            OP_JZ: begin
                                r_pc    <= r_z ? w_target : w_pc_next;
                                r_state <= ST_FETCH;
                            end
                            OP_JC: begin
                                r_pc    <= r_c ? w_target : w_pc_next;
                                r_state <= ST_FETCH;
                            end
                            default: r_state <= ST_FETCH;
                        endcase
                    end else if (w_wdog_hit) begin
                        r_wdog_err <= 1'b1;
                        r_halted   <= 1'b1;
                        r_state    <= ST_HALT;
                    end else if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_WAIT;
                        if (r_issue_count != 8'hFF) begin
                            r_issue_count <= r_issue_count + 8'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (res_valid) begin
                        r_z     <= zero_flag;
                        r_c     <= carry_flag;
                        r_v     <= overflow_flag;
                        r_pc    <= w_pc_next;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign busy        = w_busy;
    assign halted      = r_halted;
    assign issue_count = r_issue_count;
    assign wdog_err    = r_wdog_err;

    assign o_dbg.state    = r_state;
    assign o_dbg.z        = r_z;
    assign o_dbg.c        = r_c;
    assign o_dbg.v        = r_v;
    assign o_dbg.at_limit = w_at_limit;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: issued instructions are checked against an expected queue.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int DEPTH = 16;
    localparam int WLIM  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_wdata = '0;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic       res_valid = 1'b0;
    logic       zero_flag = 1'b0;
    logic       carry_flag = 1'b0;
    logic       overflow_flag = 1'b0;
    logic [3:0] pc;
    logic       busy;
    logic       halted;
    logic [7:0] issue_count;
    logic       wdog_err;
    seq_dbg_t   dbg;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_xfer = 0;
    int         resp_seen = 0;
    logic       resp_en = 1'b1;
    logic       resp_z = 1'b0;
    int         xfer0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .PROG_DEPTH (DEPTH),
        .WDOG_LIMIT (WLIM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_wdata    (prog_wdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .res_valid     (res_valid),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .issue_count   (issue_count),
        .wdog_err      (wdog_err),
        .o_dbg         (dbg)
    );

    // Monitor: every transfer pops the next expected instruction.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            n_xfer++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL issue_unexpected: got=0x%02h expected=none", instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (instr !== mon_exp) begin
                    n_errors++;
                    $display("FAIL issue_order: got=0x%02h expected=0x%02h", instr, mon_exp);
                end
            end
        end
    end

    // Processor model: one-cycle result pulse in the cycle after each transfer.
    always @(posedge clk) begin
        #1;
        if (resp_seen != n_xfer) begin
            resp_seen  = n_xfer;
            res_valid  = resp_en;
            zero_flag  = resp_z;
            carry_flag = 1'b0;
        end else begin
            res_valid  = 1'b0;
            zero_flag  = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int i = 0;
        while (!halted && i < budget) begin
            tick();
            i++;
        end
        chk({name, "_halted"}, halted, 1);
    endtask

    task automatic wait_state(input seq_state_t st, input int budget);
        int i = 0;
        while (dbg.state != st && i < budget) begin
            tick();
            i++;
        end
        chk("wait_state", dbg.state, st);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr", instr, 8'h00);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_issue", issue_count, 0);
        chk("rst_wdog", wdog_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Straight-line program, plus start-to-valid latency
        write_word(4'd0, 8'h10);
        write_word(4'd1, 8'h11);
        write_word(4'd2, 8'hF0);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        pulse_start();
        chk("lat_fetch_busy", busy, 1);
        chk("lat_fetch_valid", instr_valid, 0);
        tick();
        chk("lat_exec_valid", instr_valid, 1);
        chk("lat_exec_instr", instr, 8'h10);
        wait_halt("seq", 100);
        chk("seq_issue", issue_count, 2);
        chk("seq_pc", pc, 2);
        chk("seq_busy", busy, 0);
        chk("seq_q_empty", exp_q.size(), 0);

        // JZ taken on Z=1
        write_word(4'd0, 8'h20);
        write_word(4'd1, 8'hD3);
        write_word(4'd2, 8'h21);
        write_word(4'd3, 8'hF0);
        resp_z = 1'b1;
        exp_q.push_back(8'h20);
        pulse_start();
        wait_halt("jz_taken", 100);
        chk("jz_taken_pc", pc, 3);
        chk("jz_taken_issue", issue_count, 1);
        chk("jz_taken_q", exp_q.size(), 0);

        // JZ not taken on Z=0
        resp_z = 1'b0;
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h21);
        pulse_start();
        wait_halt("jz_fall", 100);
        chk("jz_fall_pc", pc, 3);
        chk("jz_fall_issue", issue_count, 2);
        chk("jz_fall_q", exp_q.size(), 0);

        // PC wrap 15 -> 0, then JZ sees the latched Z
        write_word(4'd0, 8'hD2);
        write_word(4'd1, 8'hCF);
        write_word(4'd2, 8'hF0);
        write_word(4'd15, 8'h12);
        resp_z = 1'b1;
        exp_q.push_back(8'h12);
        pulse_start();
        wait_halt("wrap", 100);
        chk("wrap_pc", pc, 2);
        chk("wrap_issue", issue_count, 1);
        resp_z = 1'b0;

        // Backpressure: instr_ready low for 5 cycles
        write_word(4'd0, 8'h10);
        write_word(4'd1, 8'hF0);
        instr_ready = 1'b0;
        exp_q.push_back(8'h10);
        xfer0 = n_xfer;
        pulse_start();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", instr_valid, 1);
            chk("bp_instr", instr, 8'h10);
            tick();
        end
        instr_ready = 1'b1;
        wait_halt("bp", 100);
        chk("bp_xfers", n_xfer - xfer0, 1);
        chk("bp_issue", issue_count, 1);

        // Reset mid-handshake drops instr_valid without a clock edge
        instr_ready = 1'b0;
        pulse_start();
        tick();
        chk("arst_pre_valid", instr_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", instr_valid, 0);
        chk("arst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        instr_ready = 1'b1;

        // Reset during WAIT; writes while busy are ignored
        write_word(4'd1, 8'h11);
        write_word(4'd2, 8'hF0);
        resp_en = 1'b0;
        exp_q.push_back(8'h10);
        pulse_start();
        wait_state(ST_WAIT, 20);
        write_word(4'd0, 8'h55);
        write_word(4'd1, 8'h66);
        rst_n = 1'b0;
        #1;
        chk("wrst_pc", pc, 0);
        chk("wrst_issue", issue_count, 0);
        chk("wrst_state", dbg.state, ST_IDLE);
        tick();
        rst_n = 1'b1;
        resp_en = 1'b1;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        pulse_start();
        wait_halt("wrst", 100);
        chk("wrst_issue_after", issue_count, 2);
        chk("wrst_pc_after", pc, 2);
        chk("wrst_q", exp_q.size(), 0);

        // start and prog_we together from IDLE: FETCH sees the new word
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h11);
        prog_we    = 1'b1;
        prog_addr  = 4'd0;
        prog_wdata = 8'h33;
        start      = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        wait_halt("same", 100);
        chk("same_issue", issue_count, 2);
        chk("same_q", exp_q.size(), 0);

        // Endless loop {0x10, JMP 0}
        write_word(4'd0, 8'h10);
        write_word(4'd1, 8'hC0);
`ifdef SEQ_WATCHDOG_EN
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h10);
        pulse_start();
        wait_halt("wdog", 200);
        chk("wdog_err", wdog_err, 1);
        chk("wdog_issue", issue_count, 3);
        chk("wdog_valid", instr_valid, 0);
        chk("wdog_q", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h10);
        pulse_start();
        chk("wdog_clear", wdog_err, 0);
        wait_halt("wdog2", 200);
        chk("wdog2_err", wdog_err, 1);
        chk("wdog2_issue", issue_count, 3);
`else
        for (int i = 0; i < 260; i++) exp_q.push_back(8'h10);
        xfer0 = n_xfer;
        pulse_start();
        for (int i = 0; i < 3000 && (n_xfer - xfer0) < 260; i++) tick();
        chk("loop_xfers", n_xfer - xfer0, 260);
        chk("loop_issue_sat", issue_count, 8'hFF);
        chk("loop_wdog", wdog_err, 0);
        chk("loop_halted", halted, 0);
        chk("loop_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("loop_q", exp_q.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PROG_DEPTH, default 16: number of 8-bit program words; PC width is clog2(PROG_DEPTH), which is 4 at the default.
REQ-002 Parameter WDOG_LIMIT, default 255: maximum number of issued instructions per run (used only under REQ-030).
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins execution at PC 0.
REQ-006 prog_we / prog_addr / prog_wdata  input  1/4/8  program-load write port.
REQ-007 instr  output  8  instruction presented to the processor.
REQ-008 instr_valid  output  1; instr_ready  input  1; an instruction transfers on a cycle where both are high.
REQ-009 res_valid  input  1; zero_flag, carry_flag, overflow_flag  input  1 each; a completion pulse with its flags.
REQ-010 pc  output  4; busy  output  1; halted  output  1; issue_count  output  8; wdog_err  output  1.

Function
REQ-011 Opcode is instr[7:4]; control opcodes are consumed internally and never issued to the processor.
- 4'hF: HALT.
- 4'hC: JMP to instr[3:0].
- 4'hD: JZ, taken when the latched Z flag is 1.
- 4'hE: JC, taken when the latched C flag is 1.
REQ-012 All other opcodes are data instructions and are issued to the processor unchanged.
REQ-013 State machine states are IDLE, FETCH, EXEC, WAIT, HALT.
REQ-014 IDLE -> FETCH on start; PC, latched flags and issue_count clear on that edge.
REQ-015 FETCH lasts 1 cycle: IR <= mem[pc]; the next state is EXEC.
REQ-016 EXEC, control opcode, 1 cycle:
- HALT -> HALT.
- Taken jump -> pc <= target, then FETCH.
- Untaken jump -> pc <= pc+1, then FETCH.
REQ-017 EXEC, data opcode: instr = IR and instr_valid = 1, held stable until instr_ready; on transfer -> WAIT and issue_count increments.
REQ-018 In WAIT, instr_valid = 0; on res_valid, Z/C/V are latched, pc <= pc+1, and the next state is FETCH.
REQ-019 res_valid outside WAIT is ignored.
REQ-020 pc+1 wraps from PROG_DEPTH-1 to 0.
REQ-021 issue_count saturates at 8'hFF.
REQ-022 HALT: halted = 1; start restarts exactly as in REQ-014.
REQ-023 busy = 1 in FETCH, EXEC and WAIT.
REQ-024 prog_we writes mem[prog_addr] only when busy = 0; it is ignored while busy.
REQ-025 start is ignored while busy = 1.
REQ-026 If start and prog_we arrive in the same cycle from IDLE, the write completes and the following FETCH reads the new word.
REQ-027 Minimum latency from start to instr_valid is 2 cycles (FETCH then EXEC).

Reset
REQ-028 While rst_n = 0:
- State is IDLE.
- pc, instr, instr_valid, halted, issue_count, wdog_err and the latched flags are 0.
- Program memory is not cleared.
REQ-029 Reset asserted mid-handshake drops instr_valid immediately (asynchronously), without waiting for a transfer.

Configuration
REQ-030 With SEQ_WATCHDOG_EN defined: when issue_count reaches WDOG_LIMIT, the next data transfer is suppressed, wdog_err <= 1 and the state goes to HALT. wdog_err clears on start.
REQ-031 Without SEQ_WATCHDOG_EN: wdog_err is tied to 0 and runs are unbounded.

Structure
REQ-032 A shared package seq_pkg holds the opcode localparams (OP_HALT, OP_JMP, OP_JZ, OP_JC) and the state enum type.
REQ-033 One sub-module, seq_prog_mem, holds the PROG_DEPTH x 8 array: synchronous write, combinational read.

Verification
REQ-034 Program {0x10, 0x11, 0xF0}, instr_ready tied 1, res_valid 1 cycle after each transfer -> instr shows 0x10 then 0x11, halted = 1, issue_count = 2, pc = 2.
REQ-035 Program {0x20, 0xD3, 0x21, 0xF0}, with Z = 1 returned for 0x20 -> 0x21 is never issued and pc ends at 3.
REQ-036 Same program with Z = 0 -> 0x21 is issued; issue_count = 2.
REQ-037 instr_ready held 0 for 5 cycles -> instr_valid stays 1 and instr is stable at 0x10 throughout; exactly one transfer occurs.
REQ-038 Assert rst_n = 0 during WAIT, then start -> execution restarts from pc 0; prog_we pulsed while busy leaves memory unchanged.
REQ-039 SEQ_WATCHDOG_EN, WDOG_LIMIT = 3, program {0x10, 0xC0} -> exactly 3 issues, then wdog_err = 1 and halted = 1.
